// File: rtl/sign_mag_row_skewer_pkg.sv
// rtl/sign_mag_row_skewer_pkg.sv - shared types and constants for the sign-magnitude row skewer
// Package sm_feeder_pkg: byte type, word geometry, zero encodings, skewer state enum
// and the negative-zero canonicalisation helper.
package sm_feeder_pkg;

   typedef logic [7:0] sm_byte_t;

   localparam int       SM_WORD_BYTES = 4;
   localparam sm_byte_t SM_NEG_ZERO   = 8'h80;
   localparam sm_byte_t SM_POS_ZERO   = 8'h00;

   typedef enum logic {ASSEMBLE, FULL} skew_state_e;

   // Folds sign-magnitude -0 onto +0 so downstream zero detection needs one compare.
   function automatic sm_byte_t sm_canon_zero(input sm_byte_t b);
      return (b == SM_NEG_ZERO) ? SM_POS_ZERO : b;
   endfunction

endpackage

// File: rtl/sign_mag_row_skewer_if.sv
// rtl/sign_mag_row_skewer_if.sv - input word stream interface of the row skewer
// Signals:
//   in_word_i   32  packed sign-magnitude bytes, byte k = bits [8k+7:8k]
//   in_valid_i  1   in_word_i valid
//   in_ready_o  1   word accepted when in_valid_i & in_ready_o
// Modports: master drives word/valid, slave (the skewer) drives ready.
interface sign_mag_row_skewer_if;
   import sm_feeder_pkg::*;

   logic [SM_WORD_BYTES*8-1:0] in_word_i;
   logic                       in_valid_i;
   logic                       in_ready_o;

   modport master (output in_word_i, output in_valid_i, input in_ready_o);
   modport slave  (input in_word_i, input in_valid_i, output in_ready_o);

endinterface

// File: rtl/sign_mag_row_skewer_delay_line.sv
// rtl/sign_mag_row_skewer_delay_line.sv - enable-gated skew delay line of {valid, byte}
// Module sm_skew_delay_line #(DEPTH)
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active-high; clears all stages
//   en_i         shift enable (array advance)
//   in_valid_i   stage-0 valid input
//   in_data_i    stage-0 byte input
//   out_valid_o  valid after DEPTH enabled shifts
//   out_data_o   byte after DEPTH enabled shifts
// DEPTH=0 degenerates to a wire.
module sm_skew_delay_line
   import sm_feeder_pkg::*;
#(
   parameter int DEPTH = 1
)
(
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     en_i,
   input  logic     in_valid_i,
   input  sm_byte_t in_data_i,
   output logic     out_valid_o,
   output sm_byte_t out_data_o
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign out_valid_o = in_valid_i;
         assign out_data_o  = in_data_i;
      end else begin : g_shift
         logic [DEPTH-1:0] vld_q;
         sm_byte_t         data_q [DEPTH];

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               vld_q <= '0;
               for (int i = 0; i < DEPTH; i++) begin
                  data_q[i] <= SM_POS_ZERO;
               end
            end else if (en_i) begin
               vld_q[0]  <= in_valid_i;
               data_q[0] <= in_data_i;
               for (int i = 1; i < DEPTH; i++) begin
                  vld_q[i]  <= vld_q[i-1];
                  data_q[i] <= data_q[i-1];
               end
            end
         end

         assign out_valid_o = vld_q[DEPTH-1];
         assign out_data_o  = data_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/sign_mag_row_skewer.sv
// rtl/sign_mag_row_skewer.sv - assembles sign-magnitude column vectors and feeds them skewed into array rows
// Module sign_mag_row_skewer #(ROWS)
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active-high
//   in_if        slave side of sign_mag_row_skewer_if (32-bit word stream)
//   adv_i        array advance enable; skew lines shift only when high
//   row_data_o   ROWS*8, row r operand = bits [8r+7:8r]
//   row_valid_o  ROWS, row r operand valid
//   idle_o       no partial vector, no held vector, no valid row output
// Optional feature: SM_ROW_SKEW_NEG_ZERO_CANON_EN rewrites 8'h80 bytes to 8'h00 at assembly.
module sign_mag_row_skewer
   import sm_feeder_pkg::*;
#(
   parameter int ROWS = 8
)
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   sign_mag_row_skewer_if.slave  in_if,
   input  logic                  adv_i,
   output logic [ROWS*8-1:0]     row_data_o,
   output logic [ROWS-1:0]       row_valid_o,
   output logic                  idle_o
);

   localparam int WORDS_PER_V = ROWS / SM_WORD_BYTES;
   localparam int CNT_W       = (WORDS_PER_V > 1) ? $clog2(WORDS_PER_V) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_V - 1);

   skew_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   sm_byte_t         vec_q       [ROWS];
   logic [ROWS-1:0]  head_vld_q;
   sm_byte_t         head_data_q [ROWS];

   logic     in_ready;
   logic     accept;
   logic     last_word;
   sm_byte_t in_byte [SM_WORD_BYTES];

   // While full, an advance frees the vector this cycle, so the next word may land at once.
   assign in_ready        = (state_q != FULL) | adv_i;
   assign in_if.in_ready_o = in_ready;
   assign accept          = in_if.in_valid_i & in_ready;
   assign last_word       = accept & (cnt_q == CNT_LAST);

   for (genvar k = 0; k < SM_WORD_BYTES; k++) begin : g_in_byte
`ifdef SM_ROW_SKEW_NEG_ZERO_CANON_EN
      assign in_byte[k] = sm_canon_zero(in_if.in_word_i[8*k +: 8]);
`else
      assign in_byte[k] = in_if.in_word_i[8*k +: 8];
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ASSEMBLE;
         cnt_q      <= '0;
         head_vld_q <= '0;
         for (int e = 0; e < ROWS; e++) begin
            vec_q[e]       <= SM_POS_ZERO;
            head_data_q[e] <= SM_POS_ZERO;
         end
      end else begin
         if (accept) begin
            cnt_q <= last_word ? '0 : cnt_q + CNT_W'(1);
         end

         // Word w writes elements 4w..4w+3; constant indices keep the select narrow.
         for (int e = 0; e < ROWS; e++) begin
            if (accept && (cnt_q == CNT_W'(e / SM_WORD_BYTES))) begin
               vec_q[e] <= in_byte[e % SM_WORD_BYTES];
            end
         end

         if (state_q == ASSEMBLE) begin
            if (last_word) begin
               state_q <= FULL;
            end
         end else begin
            if (adv_i && !last_word) begin
               state_q <= ASSEMBLE;
            end
         end

         // Every row head samples the held vector on the same advance; a bubble when nothing is held.
         if (adv_i) begin
            for (int r = 0; r < ROWS; r++) begin
               head_vld_q[r]  <= (state_q == FULL);
               head_data_q[r] <= (state_q == FULL) ? vec_q[r] : SM_POS_ZERO;
            end
         end
      end
   end

   assign row_valid_o[0]  = head_vld_q[0];
   assign row_data_o[7:0] = head_data_q[0];

   for (genvar r = 1; r < ROWS; r++) begin : g_row
      sm_skew_delay_line #(.DEPTH(r)) u_dly (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .en_i        (adv_i),
         .in_valid_i  (head_vld_q[r]),
         .in_data_i   (head_data_q[r]),
         .out_valid_o (row_valid_o[r]),
         .out_data_o  (row_data_o[8*r +: 8])
      );
   end

   assign idle_o = (cnt_q == '0) & (state_q != FULL) & ~|row_valid_o;

endmodule

// File: tb/tb_sign_mag_row_skewer.sv
// tb/tb_sign_mag_row_skewer.sv - directed self-checking bench for sign_mag_row_skewer
module tb_sign_mag_row_skewer;
   import sm_feeder_pkg::*;

   localparam int ROWS = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              adv;
   logic [ROWS*8-1:0] row_data;
   logic [ROWS-1:0]   row_valid;
   logic              idle;

   sign_mag_row_skewer_if in_if ();

   sign_mag_row_skewer #(.ROWS(ROWS)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_if       (in_if),
      .adv_i       (adv),
      .row_data_o  (row_data),
      .row_valid_o (row_valid),
      .idle_o      (idle)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!idle && n < 40) begin
         tick();
         n++;
      end
      expect_eq(tag, 64'(idle), 64'd1);
   endtask

   // Scoreboard: vectors in emission order, element r = bits [8r+7:8r]; each row consumes in order.
   logic [63:0] exp_vec [$];
   int          rd_idx  [ROWS];
   bit          mon_en = 1'b0;

   always @(posedge clk) begin
      #1;
      if (mon_en && !rst) begin
         for (int r = 0; r < ROWS; r++) begin
            if (row_valid[r]) begin : chk_row
               logic [63:0] v;
               if (rd_idx[r] < exp_vec.size()) begin
                  v = exp_vec[rd_idx[r]];
                  expect_eq($sformatf("row%0d_data_v%0d", r, rd_idx[r]),
                            64'(row_data[8*r +: 8]), 64'(v[8*r +: 8]));
                  rd_idx[r]++;
               end else begin
                  expect_eq($sformatf("row%0d_unexpected_valid", r), 64'(row_valid[r]), 64'd0);
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] wd;
      logic [31:0] tw [8];

      for (int r = 0; r < ROWS; r++) rd_idx[r] = 0;
      rst = 1'b1;
      adv = 1'b0;
      in_if.in_valid_i = 1'b0;
      in_if.in_word_i  = '0;

      // Reset
      repeat (2) tick();
      expect_eq("rst_row_data",  64'(row_data),         64'd0);
      expect_eq("rst_row_valid", 64'(row_valid),        64'd0);
      expect_eq("rst_in_ready",  64'(in_if.in_ready_o), 64'd1);
      expect_eq("rst_idle",      64'(idle),             64'd1);
      rst = 1'b0;
      mon_en = 1'b1;

      // Skew with constant advance
      exp_vec.push_back(64'h08070605_04030201);
      adv = 1'b1;
      in_if.in_valid_i = 1'b1;
      in_if.in_word_i  = 32'h04030201;
      tick();
      expect_eq("skew_idle_partial", 64'(idle), 64'd0);
      in_if.in_word_i = 32'h08070605;
      tick();
      in_if.in_valid_i = 1'b0;
      expect_eq("skew_full_row_valid", 64'(row_valid), 64'd0);
      expect_eq("skew_full_idle",      64'(idle),      64'd0);
      for (int k = 0; k < ROWS; k++) begin
         tick();
         expect_eq($sformatf("skew_valid_adv%0d", k + 1), 64'(row_valid), 64'(1) << k);
         expect_eq($sformatf("skew_data_adv%0d", k + 1),  64'(row_data),  64'(k + 1) << (8 * k));
      end
      tick();
      expect_eq("skew_done_valid", 64'(row_valid), 64'd0);
      expect_eq("skew_done_idle",  64'(idle),      64'd1);

      // Backpressure
      exp_vec.push_back(64'h18171615_14131211);
      exp_vec.push_back(64'h28272625_24232221);
      adv = 1'b0;
      in_if.in_valid_i = 1'b1;
      in_if.in_word_i  = 32'h14131211;
      tick();
      in_if.in_word_i = 32'h18171615;
      tick();
      in_if.in_word_i = 32'h24232221;
      #1;
      expect_eq("bp_ready_low", 64'(in_if.in_ready_o), 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         expect_eq($sformatf("bp_hold_ready_%0d", k), 64'(in_if.in_ready_o), 64'd0);
         expect_eq($sformatf("bp_hold_valid_%0d", k), 64'(row_valid),        64'd0);
         expect_eq($sformatf("bp_hold_data_%0d", k),  64'(row_data),         64'd0);
         expect_eq($sformatf("bp_hold_idle_%0d", k),  64'(idle),             64'd0);
      end
      adv = 1'b1;
      #1;
      expect_eq("bp_ready_on_adv", 64'(in_if.in_ready_o), 64'd1);
      tick();
      in_if.in_word_i = 32'h28272625;
      tick();
      in_if.in_valid_i = 1'b0;
      wait_idle("bp_idle_timeout");

      // Throughput: 4 vectors, one word per cycle
      for (int i = 0; i < 8; i++) tw[i] = 32'h43424140 + 32'(i) * 32'h04040404;
      for (int j = 0; j < 4; j++) exp_vec.push_back({tw[2*j+1], tw[2*j]});
      adv = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         if (c <= 8) begin
            in_if.in_valid_i = 1'b1;
            in_if.in_word_i  = tw[c-1];
         end else begin
            in_if.in_valid_i = 1'b0;
         end
         tick();
         if (c >= 3) begin
            expect_eq($sformatf("tput_row0_c%0d", c), 64'(row_valid[0]), 64'(((c - 3) % 2) == 0));
         end
      end
      wait_idle("tput_idle_timeout");

      // Negative zero
`ifdef SM_ROW_SKEW_NEG_ZERO_CANON_EN
      exp_vec.push_back(64'h7F00FF00_00000000);
`else
      exp_vec.push_back(64'h7F00FF80_80808080);
`endif
      in_if.in_valid_i = 1'b1;
      in_if.in_word_i  = 32'h80808080;
      tick();
      in_if.in_word_i = 32'h7F00FF80;
      tick();
      in_if.in_valid_i = 1'b0;
      wait_idle("negz_idle_timeout");

      // Reset mid-operation
      adv = 1'b0;
      in_if.in_valid_i = 1'b1;
      in_if.in_word_i  = 32'h11111111;
      tick();
      expect_eq("rstmid_partial_idle", 64'(idle), 64'd0);
      in_if.in_valid_i = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      expect_eq("rstmid_idle",      64'(idle),      64'd1);
      expect_eq("rstmid_row_valid", 64'(row_valid), 64'd0);
      exp_vec.push_back(64'hBBBBBBBB_AAAAAAAA);
      adv = 1'b1;
      in_if.in_valid_i = 1'b1;
      in_if.in_word_i  = 32'hAAAAAAAA;
      tick();
      in_if.in_word_i = 32'hBBBBBBBB;
      tick();
      in_if.in_valid_i = 1'b0;
      wait_idle("rstmid_idle_timeout");
      repeat (2) tick();

      for (int r = 0; r < ROWS; r++) begin
         expect_eq($sformatf("row%0d_count", r), 64'(rd_idx[r]), 64'(exp_vec.size()));
      end
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
